// File: rtl/alu_pkg.sv
// Shared ALU/writeback types: widths, opcodes and the pipeline packet carried by the P register.
package alu_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OVF_W     = 2;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned RF_ADDR_W = 3;
    localparam int unsigned CNT_W     = 16;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_XOR = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]    data;
        logic [OP_W-1:0]      op;
        logic [OVF_W-1:0]     ovf;
        logic                 zf;
    } wb_pkt_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: one synchronous write port, two combinational read ports,
// synchronous active-low clear of every entry.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Clear has priority so a result committing on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-cycle P holding register, register-file commit, add flags and retire count.
// Build option ALU_WB_BYPASS_EN forwards P to the read ports; otherwise reads of P's destination raise hazard.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [OP_W-1:0]   wb_op,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [OVF_W-1:0]  wb_ovf,
    input  logic              wb_zf,
    input  logic              ra_en,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              hazard,
    output logic [OVF_W-1:0]  flag_ovf,
    output logic              flag_z,
    output logic              ovf_sticky,
    input  logic              flag_clr,
    output logic [CNT_W-1:0]  retire_cnt
);

    wb_pkt_t           wb_pkt;
    wb_pkt_t           p_q;
    logic              p_valid_q;
    logic [ADDR_W-1:0] p_dest;
    logic              commit_add;
    logic              ovf_set;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    always_comb begin
        wb_pkt      = '0;
        wb_pkt.dest = RF_ADDR_W'(wb_dest);
        wb_pkt.data = wb_data;
        wb_pkt.op   = wb_op;
        wb_pkt.ovf  = wb_ovf;
        wb_pkt.zf   = wb_zf;
    end

    assign p_dest     = ADDR_W'(p_q.dest);
    assign commit_add = p_valid_q && (p_q.op == OP_ADD);
    assign ovf_set    = commit_add && (|p_q.ovf);

    // Capture into P and commit the previous P on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_valid_q  <= 1'b0;
            p_q        <= '0;
            flag_ovf   <= '0;
            flag_z     <= 1'b0;
            ovf_sticky <= 1'b0;
            retire_cnt <= '0;
        end else begin
            p_valid_q <= wb_valid;
            if (wb_valid) begin
                p_q <= wb_pkt;
            end
            if (p_valid_q) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (commit_add) begin
                flag_ovf <= p_q.ovf;
                flag_z   <= p_q.zf;
            end
            // A committing overflow beats a simultaneous clear.
            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (flag_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    alu_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (p_valid_q),
        .waddr   (p_dest),
        .wdata   (p_q.data),
        .raddr_a (ra_addr),
        .rdata_a (rf_a),
        .raddr_b (rb_addr),
        .rdata_b (rf_b)
    );

`ifdef ALU_WB_BYPASS_EN
    logic unused_en;
    assign unused_en = ra_en ^ rb_en;

    assign ra_data = (p_valid_q && (p_dest == ra_addr)) ? p_q.data : rf_a;
    assign rb_data = (p_valid_q && (p_dest == rb_addr)) ? p_q.data : rf_b;
    assign hazard  = 1'b0;
`else
    assign ra_data = rf_a;
    assign rb_data = rf_b;
    assign hazard  = p_valid_q && ((ra_en && (p_dest == ra_addr)) ||
                                   (rb_en && (p_dest == rb_addr)));
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a result-level model checked every cycle plus literal expectations.
module tb_alu_writeback;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_valid;
    logic [2:0]        wb_op;
    logic [2:0]        wb_dest;
    logic [7:0]        wb_data;
    logic [1:0]        wb_ovf;
    logic              wb_zf;
    logic              ra_en, rb_en;
    logic [2:0]        ra_addr, rb_addr;
    logic [7:0]        ra_data, rb_data;
    logic              hazard;
    logic [1:0]        flag_ovf;
    logic              flag_z;
    logic              ovf_sticky;
    logic              flag_clr;
    logic [15:0]       retire_cnt;

    alu_writeback #(.ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_op      (wb_op),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .wb_ovf     (wb_ovf),
        .wb_zf      (wb_zf),
        .ra_en      (ra_en),
        .rb_en      (rb_en),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .hazard     (hazard),
        .flag_ovf   (flag_ovf),
        .flag_z     (flag_z),
        .ovf_sticky (ovf_sticky),
        .flag_clr   (flag_clr),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

`ifdef ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Model: register array, the single result waiting to commit, flags, commit count.
    logic [7:0]  m_rf [8];
    logic        m_pv;
    logic [2:0]  m_pdest;
    logic [7:0]  m_pdata;
    logic [2:0]  m_pop;
    logic [1:0]  m_povf;
    logic        m_pzf;
    logic [1:0]  m_fovf;
    logic        m_fz;
    logic        m_sticky;
    logic [15:0] m_commits;
    logic [15:0] cnt_base = 16'h0000;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
            m_pv = 1'b0; m_pdest = '0; m_pdata = '0; m_pop = '0; m_povf = '0; m_pzf = 1'b0;
            m_fovf = 2'b00; m_fz = 1'b0; m_sticky = 1'b0; m_commits = 16'h0000;
        end else begin
            if (m_pv) begin
                m_rf[m_pdest] = m_pdata;
                m_commits = m_commits + 16'd1;
                if (m_pop == 3'b100) begin
                    m_fovf = m_povf;
                    m_fz = m_pzf;
                end
            end
            if (m_pv && m_pop == 3'b100 && m_povf != 2'b00) m_sticky = 1'b1;
            else if (flag_clr) m_sticky = 1'b0;
            m_pv = wb_valid;
            if (wb_valid) begin
                m_pdest = wb_dest; m_pdata = wb_data; m_pop = wb_op; m_povf = wb_ovf; m_pzf = wb_zf;
            end
        end
    end

    function automatic logic [7:0] m_read(input logic [2:0] a);
        if (BYP && m_pv && m_pdest == a) return m_pdata;
        return m_rf[a];
    endfunction

    // Literal expectations posted by the driver and checked at the next falling edge.
    localparam int S_RA = 0, S_RB = 1, S_HZ = 2, S_OVF = 3, S_Z = 4, S_STK = 5, S_CNT = 6;
    int          lit_n = 0;
    int          lit_sel [4];
    logic [15:0] lit_exp [4];
    string       lit_name [4];
    bit          check_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] dut_sig(input int sel);
        case (sel)
            S_RA:    return 16'(ra_data);
            S_RB:    return 16'(rb_data);
            S_HZ:    return 16'(hazard);
            S_OVF:   return 16'(flag_ovf);
            S_Z:     return 16'(flag_z);
            S_STK:   return 16'(ovf_sticky);
            default: return retire_cnt;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [15:0] e [7];
            logic [15:0] a [7];
            string nm [7];
            e[0] = 16'(m_read(ra_addr)); a[0] = 16'(ra_data);  nm[0] = "ra_data";
            e[1] = 16'(m_read(rb_addr)); a[1] = 16'(rb_data);  nm[1] = "rb_data";
            e[2] = 16'((!BYP) && m_pv && ((ra_en && m_pdest == ra_addr) || (rb_en && m_pdest == rb_addr)));
            a[2] = 16'(hazard); nm[2] = "hazard";
            e[3] = 16'(m_fovf);   a[3] = 16'(flag_ovf);   nm[3] = "flag_ovf";
            e[4] = 16'(m_fz);     a[4] = 16'(flag_z);     nm[4] = "flag_z";
            e[5] = 16'(m_sticky); a[5] = 16'(ovf_sticky); nm[5] = "ovf_sticky";
            e[6] = 16'(cnt_base + m_commits); a[6] = retire_cnt; nm[6] = "retire_cnt";
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (a[k] !== e[k]) begin
                    n_fail++;
                    $display("FAIL model %s at %0t: got %h expected %h", nm[k], $time, a[k], e[k]);
                end
            end
            for (int k = 0; k < lit_n; k++) begin
                n_checks++;
                if (dut_sig(lit_sel[k]) !== lit_exp[k]) begin
                    n_fail++;
                    $display("FAIL literal %s at %0t: got %h expected %h",
                             lit_name[k], $time, dut_sig(lit_sel[k]), lit_exp[k]);
                end
            end
        end
    end

    task automatic expect_lit(input string name, input int sel, input logic [15:0] v);
        lit_name[lit_n] = name;
        lit_sel[lit_n]  = sel;
        lit_exp[lit_n]  = v;
        lit_n++;
    endtask

    task automatic cyc();
        @(posedge clk);
        lit_n = 0;
        #2;
    endtask

    task automatic wb(input logic v, input logic [2:0] op, input logic [2:0] d,
                      input logic [7:0] dat, input logic [1:0] o, input logic z);
        wb_valid = v; wb_op = op; wb_dest = d; wb_data = dat; wb_ovf = o; wb_zf = z;
    endtask

    initial begin
        rst_n = 1'b0; flag_clr = 1'b0;
        ra_en = 1'b0; rb_en = 1'b0; ra_addr = '0; rb_addr = '0;
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        check_en = 1'b1;
        cyc();
        rst_n = 1'b1;

        // Fill registers 1..4, then confirm a few reads and the count.
        for (int i = 1; i <= 4; i++) begin
            wb(1'b1, OP_AND, 3'(i), 8'(i * 17), 2'b00, 1'b0);
            cyc();
        end
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        ra_addr = 3'd2; rb_addr = 3'd4;
        expect_lit("load_ra2", S_RA, 16'h0022);
        expect_lit("load_rb4", S_RB, 16'h0044);
        expect_lit("load_cnt", S_CNT, 16'd4);
        cyc();

        // Reset with a result in P, and a valid presented during reset.
        wb(1'b1, OP_ADD, 3'd7, 8'h77, 2'b11, 1'b0);
        cyc();
        rst_n = 1'b0;
        wb(1'b1, OP_XOR, 3'd6, 8'h66, 2'b00, 1'b0);
        cyc();
        rst_n = 1'b1;
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        ra_addr = 3'd7; rb_addr = 3'd2;
        expect_lit("rst_ra7", S_RA, 16'h0000);
        expect_lit("rst_rb2", S_RB, 16'h0000);
        expect_lit("rst_cnt", S_CNT, 16'h0000);
        expect_lit("rst_stk", S_STK, 16'h0000);
        cyc();
        ra_addr = 3'd6;
        cyc();
        expect_lit("rst_ra6", S_RA, 16'h0000);
        expect_lit("rst_cnt2", S_CNT, 16'h0000);
        cyc();

        // Add with overflow, then an XOR that must not touch the flags.
        wb(1'b1, OP_ADD, 3'd3, 8'h00, 2'b01, 1'b1);
        cyc();
        wb(1'b1, OP_XOR, 3'd2, 8'h5A, 2'b11, 1'b0);
        ra_addr = 3'd3;
        cyc();
        expect_lit("add_ovf", S_OVF, 16'h0001);
        expect_lit("add_z", S_Z, 16'h0001);
        expect_lit("add_stk", S_STK, 16'h0001);
        expect_lit("add_cnt", S_CNT, 16'd1);
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        ra_addr = 3'd2;
        expect_lit("xor_ra2", S_RA, 16'h005A);
        expect_lit("xor_ovf", S_OVF, 16'h0001);
        expect_lit("xor_z", S_Z, 16'h0001);
        expect_lit("xor_cnt", S_CNT, 16'd2);
        cyc();

        // Back-to-back writes to register 5.
        wb(1'b1, OP_AND, 3'd5, 8'hAA, 2'b00, 1'b0);
        cyc();
        wb(1'b1, OP_AND, 3'd5, 8'h55, 2'b00, 1'b0);
        ra_addr = 3'd5;
        cyc();
        expect_lit("b2b_ra5_a", S_RA, BYP ? 16'h0055 : 16'h00AA);
        expect_lit("b2b_cnt_a", S_CNT, 16'd3);
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        expect_lit("b2b_ra5_b", S_RA, 16'h0055);
        expect_lit("b2b_cnt_b", S_CNT, 16'd4);
        cyc();

        // Read of the in-flight register, with and without the enable.
        wb(1'b1, OP_AND, 3'd5, 8'h3C, 2'b00, 1'b0);
        cyc();
        wb(1'b1, OP_AND, 3'd5, 8'hC3, 2'b00, 1'b0);
        ra_en = 1'b1;
        expect_lit("inf_ra5", S_RA, BYP ? 16'h003C : 16'h0055);
        expect_lit("inf_hz_en", S_HZ, BYP ? 16'h0000 : 16'h0001);
        cyc();
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        ra_en = 1'b0;
        expect_lit("inf_ra5_b", S_RA, BYP ? 16'h00C3 : 16'h003C);
        expect_lit("inf_hz_dis", S_HZ, 16'h0000);
        cyc();
        cyc();

        // Clear colliding with an overflowing add, then clear alone.
        wb(1'b1, OP_ADD, 3'd0, 8'h10, 2'b10, 1'b0);
        cyc();
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        flag_clr = 1'b1;
        cyc();
        expect_lit("clr_col_stk", S_STK, 16'h0001);
        expect_lit("clr_col_ovf", S_OVF, 16'h0002);
        expect_lit("clr_col_z", S_Z, 16'h0000);
        cyc();
        expect_lit("clr_alone_stk", S_STK, 16'h0000);
        flag_clr = 1'b0;
        cyc();

        // Non-overflowing add updates flags but not the sticky bit.
        wb(1'b1, OP_ADD, 3'd1, 8'h00, 2'b00, 1'b1);
        cyc();
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        expect_lit("add0_ovf", S_OVF, 16'h0000);
        expect_lit("add0_z", S_Z, 16'h0001);
        expect_lit("add0_stk", S_STK, 16'h0000);
        expect_lit("add0_cnt", S_CNT, 16'd8);
        cyc();

        // Mixed opcodes including 101..111, with live reads on both ports.
        rb_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wb(1'b1, 3'(i), 3'(i), 8'(i * 37), 2'(i), 1'(i));
            ra_addr = 3'(i + 1);
            rb_addr = 3'(i);
            ra_en   = 1'(i);
            cyc();
        end
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        ra_en = 1'b0; rb_en = 1'b0;
        cyc();
        cyc();

        // Counter wrap from a preset value.
        force dut.retire_cnt = 16'hFFFE;
        cnt_base = 16'hFFFE - m_commits;
        cyc();
        release dut.retire_cnt;
        expect_lit("wrap_pre", S_CNT, 16'hFFFE);
        wb(1'b1, OP_AND, 3'd4, 8'h01, 2'b00, 1'b0);
        cyc();
        wb(1'b1, OP_AND, 3'd4, 8'h02, 2'b00, 1'b0);
        cyc();
        expect_lit("wrap_ffff", S_CNT, 16'hFFFF);
        wb(1'b0, 3'b000, 3'd0, 8'h00, 2'b00, 1'b0);
        cyc();
        expect_lit("wrap_zero", S_CNT, 16'h0000);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the 8-bit ALU. It consumes each ALU result (OUT, OVERFLOW, ZF), holds it for one pipeline cycle, then commits it to the architectural register file and the flag registers. It also supplies the two combinational read ports that feed the ALU's R1/R2 operands. Hazards on the in-flight result are either bypassed or flagged, depending on build configuration.

## Interface
- ADDR_W, 3, register-address width; register count NUM_REGS = 2**ADDR_W, so every address is valid
- CLK  in  1  clock, all state updates on the rising edge
- RST_N  in  1  reset, synchronous, active-low
- WB_VALID  in  1  ALU result present this cycle
- WB_OP  in  3  opcode that produced the result
- WB_DEST  in  ADDR_W  destination register
- WB_DATA  in  8  ALU OUT
- WB_OVF  in  2  ALU OVERFLOW
- WB_ZF  in  1  ALU ZF
- RA_EN, RB_EN  in  1 each  operand read is live (hazard qualification only)
- RA_ADDR, RB_ADDR  in  ADDR_W each  operand read addresses
- RA_DATA, RB_DATA  out  8 each  operand data (combinational)
- HAZARD  out  1  stall request to the upstream stage
- FLAG_OVF  out  2  last committed add overflow
- FLAG_Z  out  1  last committed add zero flag
- OVF_STICKY  out  1  set by any committed add with nonzero overflow
- FLAG_CLR  in  1  clears OVF_STICKY
- RETIRE_CNT  out  16  count of committed results

## Operation
- **Stage P (capture).** On each edge, P_VALID <= WB_VALID. When WB_VALID=1, capture {WB_DEST, WB_DATA, WB_OP, WB_OVF, WB_ZF} into P. There is no backpressure: a capture happens every cycle WB_VALID=1.
- **Commit.** On each edge with P_VALID=1:
  - RF[P_DEST] <= P_DATA.
  - RETIRE_CNT increments, wrapping 0xFFFF -> 0x0000.
  - If P_OP == OP_ADD (3'b100): FLAG_OVF <= P_OVF, FLAG_Z <= P_ZF, and OVF_STICKY is set when P_OVF != 0.
  - All other opcodes leave the flags unchanged. This includes 3'b101–3'b111, whose result (0) is still written to the register file.
- **Capture and commit on the same edge.** Both operate: the old P commits while the new result loads into P.
- **FLAG_CLR.** Clears OVF_STICKY on the edge. If FLAG_CLR is asserted on the same edge as a committing overflowing add, the set wins: OVF_STICKY=1.
- **Reads.** RA_DATA and RB_DATA return RF[addr], with bypass from P per Configuration. WB_* inputs are never forwarded to the read ports; this avoids a combinational loop through the ALU.
- **Reset** (RST_N=0 at an edge):
  - All RF entries = 0, P_VALID = 0, FLAG_OVF = 0, FLAG_Z = 0, OVF_STICKY = 0, RETIRE_CNT = 0.
  - An in-flight P result is discarded, not committed.
  - WB_VALID is ignored while RST_N=0.

## Timing
- Result presented with WB_VALID=1 in cycle n:
  - Sits in P after edge n.
  - Is in RF and the flags after edge n+1.
  - Is visible from RF in cycle n+2.
- With bypass, the result is readable in cycle n+1.
- HAZARD and the read data are purely combinational from the current state and the read addresses.
- After reset deassertion, the first WB_VALID is accepted on the first edge with RST_N=1.

## Configuration
- Macro: ALU_WB_BYPASS_EN.
- **Defined:**
  - RA_DATA = P_DATA when P_VALID and P_DEST == RA_ADDR; otherwise RF[RA_ADDR].
  - RB_DATA follows the same rule with RB_ADDR.
  - HAZARD is tied to 0.
- **Undefined:**
  - Reads always return RF.
  - HAZARD = P_VALID && ((RA_EN && P_DEST == RA_ADDR) || (RB_EN && P_DEST == RB_ADDR)).
  - Upstream must hold the instruction while HAZARD=1.

## Structure
- Shared package alu_pkg holds:
  - DATA_W = 8 and OVF_W = 2.
  - Opcode constants OP_AND = 3'b000, OP_XOR = 3'b001, OP_SHL = 3'b010, OP_SHR = 3'b011, OP_ADD = 3'b100.
  - A packed struct wb_pkt_t {dest, data, op, ovf, zf} used for the P register.
- One sub-module, alu_regfile: NUM_REGS x 8 storage with one synchronous write port, two combinational read ports and synchronous active-low clear.
- Bypass, hazard logic, flags and the retire counter live in alu_writeback.

## Test plan
- **Reset:** load RF via writes, then pulse RST_N=0 for one edge -> all reads 0, flags 0, RETIRE_CNT=0, an in-flight P value is not committed.
- **Add with overflow:** WB_OP=100, WB_DEST=3, WB_DATA=0x00, WB_OVF=01, WB_ZF=1 -> after two edges RF[3]=0x00, FLAG_OVF=01, FLAG_Z=1, OVF_STICKY=1. A following XOR result leaves the flags unchanged.
- **Back-to-back writes:** WB_DEST=5 with 0xAA, then 0x55 on consecutive cycles -> RF[5]=0xAA then 0x55, RETIRE_CNT increments on both edges.
- **Read of the in-flight register:** RA_ADDR=5 the cycle after WB_DEST=5, WB_DATA=0x3C:
  - ALU_WB_BYPASS_EN defined -> RA_DATA=0x3C, HAZARD=0.
  - ALU_WB_BYPASS_EN undefined -> RA_DATA = old RF[5], HAZARD=1 (RA_EN=1), and HAZARD=0 when RA_EN=0.
- **FLAG_CLR collision:** FLAG_CLR=1 on the same edge as a committing add with OVF=10 -> OVF_STICKY=1. FLAG_CLR alone -> 0.
- **Counter wrap:** preload RETIRE_CNT near 0xFFFF via 0xFFFF commits (or force), then one more commit -> 0x0000.
